if_id_latch: RTL and testbench
==============================

IF_ID_LATCH -- requirements
Module: if_id_latch

Interface
REQ-001 SHALL take parameter NOP_WORD, default 32'h00000000, as the instruction word driven on a bubble.
REQ-002 SHALL take parameter CNT_W, default 32, as the performance counter width.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ihit, input, 1, meaning the icache returns a valid instruction this cycle.
REQ-006 SHALL have port imemload, input, word_t, the instruction word from the icache.
REQ-007 SHALL have port pc_i, input, word_t, the address of the instruction being fetched (the PC register output).
REQ-008 SHALL have port npc_i, input, word_t, pc_i + 4.
REQ-009 SHALL have port stall, input, 1, the hazard unit's request to hold decode.
REQ-010 SHALL have port flush, input, 1, a taken branch or jump that squashes the fetched instruction.
REQ-011 SHALL have port halt, input, 1, the halt decode from the control unit.
REQ-012 SHALL have outputs instr_o, pc_o, npc_o (word_t each) and valid_o (1), the registered IF/ID contents.
REQ-013 SHALL have output halted_o, 1, a sticky halt flag.
REQ-014 SHALL have outputs fetch_cnt and bubble_cnt, CNT_W each, the performance counters.

Function
REQ-015 Per-edge priority SHALL be: halted_o, then flush, then stall, then load, then bubble.
REQ-016 When halted_o=1, every edge SHALL write a bubble: instr_o=NOP_WORD, valid_o=0, pc_o and npc_o held.
REQ-017 When flush=1 and not halted, the edge SHALL write a bubble, overriding stall and ihit.
REQ-018 When stall=1 and no flush, all outputs SHALL hold their values, including valid_o.
REQ-019 On load (ihit=1, stall=0, flush=0, halt=0), the edge SHALL capture imemload, pc_i and npc_i, and set valid_o=1.
REQ-020 When ihit=0, stall=0 and flush=0, the edge SHALL write a bubble; pc_o and npc_o hold.
REQ-021 On halt=1 with no flush, the edge SHALL set halted_o=1 and write a bubble; halted_o clears only on reset.
REQ-022 Latency from imemload to instr_o SHALL be exactly one cycle on load; there is no combinational path from input to output.
REQ-023 The block SHALL have exactly two states, RUN and HALTED. RUN->HALTED occurs on halt=1 with flush=0. HALTED is absorbing.

Reset
REQ-024 On nRST low, regardless of the clock, the outputs SHALL be: instr_o=NOP_WORD, pc_o=0, npc_o=0, valid_o=0, halted_o=0, fetch_cnt=0, bubble_cnt=0.
REQ-025 Reset asserted mid-stall or in HALTED SHALL return the block to RUN with the values in REQ-024. The first load follows the first qualifying edge after deassertion.

Configuration
REQ-026 With macro IF_ID_PERF_EN defined, fetch_cnt SHALL increment on each load edge and bubble_cnt on each bubble edge. Both counters saturate at all-ones and are not affected by stall edges.
REQ-027 Without IF_ID_PERF_EN, fetch_cnt and bubble_cnt SHALL remain present, tied to 0, and no counter flops are inferred.

Verification
REQ-028 Reset then ihit=1, imemload=32'h2008000A, pc_i=0x0, npc_i=0x4 -> next edge: instr_o=32'h2008000A, pc_o=0x0, npc_o=0x4, valid_o=1.
REQ-029 After a load, stall=1 for 3 cycles while imemload changes -> outputs are unchanged for all 3 cycles. With PERF, fetch_cnt stays 1.
REQ-030 flush=1, stall=1, ihit=1 on the same edge -> instr_o=0, valid_o=0. With PERF, bubble_cnt increments by 1.
REQ-031 halt=1 for one cycle, then ihit=1 continuously -> halted_o=1 and valid_o=0 on every following edge. nRST pulse -> halted_o=0 and the next ihit loads.
REQ-032 ihit=0 for 2 cycles with no stall -> two bubbles, pc_o held. With PERF, bubble_cnt=2. Without PERF, both counters read 0.
REQ-033 With PERF and CNT_W=4, 20 consecutive loads -> fetch_cnt=4'hF, no wrap.

Source files
------------

// File: rtl/if_id_latch.sv
// IF/ID pipeline latch: registers the fetched instruction, handles stall/flush/halt bubbles.
// Optional saturating fetch/bubble performance counters are enabled by the IF_ID_PERF_EN macro.

package if_id_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic {RUN, HALTED} state_e;
    typedef enum logic [1:0] {OP_HOLD, OP_LOAD, OP_BUBBLE} op_e;
endpackage

module if_id_latch
    import if_id_pkg::*;
#(
    parameter word_t       NOP_WORD = 32'h00000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  word_t            imemload,
    input  word_t            pc_i,
    input  word_t            npc_i,
    input  logic             stall,
    input  logic             flush,
    input  logic             halt,
    output word_t            instr_o,
    output word_t            pc_o,
    output word_t            npc_o,
    output logic             valid_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    state_e state, next_state;
    op_e    op;

    always_comb begin
        // NOTE: defaults are assigned first so every path drives every signal; no latch is inferred.
        next_state = state;
        op         = OP_HOLD;
        case (state)
            RUN: begin
                if (flush) begin
                    op = OP_BUBBLE;
                end else if (halt) begin
                    op         = OP_BUBBLE;
                    next_state = HALTED;
                end else if (stall) begin
                    op = OP_HOLD;
                end else if (ihit) begin
                    op = OP_LOAD;
                end else begin
                    op = OP_BUBBLE;
                end
            end
            HALTED: op = OP_BUBBLE;
            default: begin
                next_state = RUN;
                op         = OP_BUBBLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    assign halted_o = (state == HALTED);

    // A bubble clears the instruction and valid bit but keeps the last PC pair.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instr_o <= NOP_WORD;
            pc_o    <= '0;
            npc_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            case (op)
                OP_LOAD: begin
                    instr_o <= imemload;
                    pc_o    <= pc_i;
                    npc_o   <= npc_i;
                    valid_o <= 1'b1;
                end
                OP_BUBBLE: begin
                    instr_o <= NOP_WORD;
                    valid_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef IF_ID_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (op == OP_LOAD && fetch_cnt != '1) begin
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
            if (op == OP_BUBBLE && bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign fetch_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_latch.sv
// Scoreboard bench for if_id_latch: stimulus pushes hand-computed expectations, a monitor pops and compares.
// A second instance with CNT_W=4 checks counter saturation.

module tb_if_id_latch;
    import if_id_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, stall, flush, halt;
    word_t       imemload, pc_i, npc_i;
    word_t       instr_o, pc_o, npc_o;
    logic        valid_o, halted_o;
    logic [31:0] fetch_cnt, bubble_cnt;

    word_t       d4_instr, d4_pc, d4_npc;
    logic        d4_valid, d4_halted;
    logic [3:0]  d4_fcnt, d4_bcnt;

    always #5 CLK = ~CLK;

    if_id_latch u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .pc_i(pc_i), .npc_i(npc_i),
        .stall(stall), .flush(flush), .halt(halt),
        .instr_o(instr_o), .pc_o(pc_o), .npc_o(npc_o), .valid_o(valid_o), .halted_o(halted_o),
        .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
    );

    if_id_latch #(.CNT_W(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .pc_i(pc_i), .npc_i(npc_i),
        .stall(stall), .flush(flush), .halt(halt),
        .instr_o(d4_instr), .pc_o(d4_pc), .npc_o(d4_npc), .valid_o(d4_valid), .halted_o(d4_halted),
        .fetch_cnt(d4_fcnt), .bubble_cnt(d4_bcnt)
    );

    typedef struct packed {
        word_t       instr;
        word_t       pc;
        word_t       npc;
        logic        valid;
        logic        halted;
        logic [31:0] fc;
        logic [31:0] bc;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic logic [31:0] pf(input int v);
`ifdef IF_ID_PERF_EN
        return v;
`else
        return (v == v) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: the latch presents a new word after every edge; compare it against the oldest expectation.
    obs_t  m_exp, m_act;
    string m_name;
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                m_exp  = exp_q.pop_front();
                m_name = name_q.pop_front();
                m_act  = {instr_o, pc_o, npc_o, valid_o, halted_o, fetch_cnt, bubble_cnt};
                n_checks++;
                if (m_act !== m_exp) begin
                    n_fail++;
                    $display("FAIL %s: got instr=%h pc=%h npc=%h v=%b h=%b fc=%0d bc=%0d expected instr=%h pc=%h npc=%h v=%b h=%b fc=%0d bc=%0d",
                             m_name, m_act.instr, m_act.pc, m_act.npc, m_act.valid, m_act.halted, m_act.fc, m_act.bc,
                             m_exp.instr, m_exp.pc, m_exp.npc, m_exp.valid, m_exp.halted, m_exp.fc, m_exp.bc);
                end
            end
        end
    end

    task automatic step(input string nm, input logic ih, input logic st, input logic fl, input logic ht,
                        input word_t im, input word_t pc,
                        input word_t e_instr, input word_t e_pc, input logic e_v, input logic e_h,
                        input int e_fc, input int e_bc);
        ihit     = ih;
        stall    = st;
        flush    = fl;
        halt     = ht;
        imemload = im;
        pc_i     = pc;
        npc_i    = pc + 32'd4;
        exp_q.push_back({e_instr, e_pc, e_pc + 32'd4, e_v, e_h, pf(e_fc), pf(e_bc)});
        name_q.push_back(nm);
        @(posedge CLK);
        #2;
    endtask

    // Assert reset away from any edge and check the outputs clear without waiting for the clock.
    task automatic rst_pulse(input string tag);
        nRST = 1'b0;
        #1;
        check({tag, "_instr"},  instr_o, 32'h0);
        check({tag, "_pc"},     pc_o, 32'h0);
        check({tag, "_npc"},    npc_o, 32'h0);
        check({tag, "_valid"},  {31'b0, valid_o}, 32'h0);
        check({tag, "_halted"}, {31'b0, halted_o}, 32'h0);
        check({tag, "_fcnt"},   fetch_cnt, 32'h0);
        check({tag, "_bcnt"},   bubble_cnt, 32'h0);
        @(posedge CLK);
        #2;
        nRST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST = 1'b1; ihit = 1'b0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
        imemload = '0; pc_i = '0; npc_i = 32'd4;
        #2;
        rst_pulse("rst0");

        step("load0", 1, 0, 0, 0, 32'h2008000A, 32'h0, 32'h2008000A, 32'h0, 1, 0, 1, 0);
        step("stall0", 1, 1, 0, 0, 32'hDEADBEEF, 32'h4, 32'h2008000A, 32'h0, 1, 0, 1, 0);
        step("stall1", 1, 1, 0, 0, 32'h11111111, 32'h8, 32'h2008000A, 32'h0, 1, 0, 1, 0);
        step("stall2", 0, 1, 0, 0, 32'h22222222, 32'hC, 32'h2008000A, 32'h0, 1, 0, 1, 0);
        step("load1", 1, 0, 0, 0, 32'h8C010004, 32'h4, 32'h8C010004, 32'h4, 1, 0, 2, 0);
        step("flush_stall", 1, 1, 1, 0, 32'hAAAA5555, 32'h8, 32'h0, 32'h4, 0, 0, 2, 1);
        step("load2", 1, 0, 0, 0, 32'h00221820, 32'h100, 32'h00221820, 32'h100, 1, 0, 3, 1);
        step("miss0", 0, 0, 0, 0, 32'h55555555, 32'h104, 32'h0, 32'h100, 0, 0, 3, 2);
        step("miss1", 0, 0, 0, 0, 32'h66666666, 32'h104, 32'h0, 32'h100, 0, 0, 3, 3);
        step("stall_bubble", 1, 1, 0, 0, 32'h77777777, 32'h104, 32'h0, 32'h100, 0, 0, 3, 3);
        step("load3", 1, 0, 0, 0, 32'h12345678, 32'h200, 32'h12345678, 32'h200, 1, 0, 4, 3);
        step("halt", 1, 0, 0, 1, 32'hFFFFFFFF, 32'h204, 32'h0, 32'h200, 0, 1, 4, 4);
        step("halted0", 1, 0, 0, 0, 32'h0BADF00D, 32'h208, 32'h0, 32'h200, 0, 1, 4, 5);
        step("halted1", 1, 1, 0, 0, 32'h0BADF00D, 32'h208, 32'h0, 32'h200, 0, 1, 4, 6);
        step("halted2", 1, 0, 1, 0, 32'h0BADF00D, 32'h208, 32'h0, 32'h200, 0, 1, 4, 7);

        rst_pulse("rst1");
        step("load4", 1, 0, 0, 0, 32'h2008000A, 32'h300, 32'h2008000A, 32'h300, 1, 0, 1, 0);
        step("flush_halt", 1, 0, 1, 1, 32'h99999999, 32'h304, 32'h0, 32'h300, 0, 0, 1, 1);
        step("load5", 1, 0, 0, 0, 32'hAC220008, 32'h304, 32'hAC220008, 32'h304, 1, 0, 2, 1);

        rst_pulse("rst2");
        for (int i = 0; i < 20; i++) begin
            step($sformatf("sat%0d", i), 1, 0, 0, 0, word_t'(i * 3 + 1), word_t'(i * 4),
                 word_t'(i * 3 + 1), word_t'(i * 4), 1, 0, i + 1, 0);
        end
        check("cnt4_fetch_sat", {28'h0, d4_fcnt}, pf(15));
        check("cnt4_bubble", {28'h0, d4_bcnt}, 32'h0);

        ihit = 1'b0;
        @(posedge CLK);
        #2;
        check("scoreboard_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
